aes_key_loader: RTL and testbench
=================================

# aes_key_loader

Host-side key loader that sits directly upstream of `Key_Expansion`. It accepts the cipher key as a stream of 32-bit words over a valid/ready handshake and assembles them into the 256-bit `CipherKey` bus. It then issues a one-cycle `k_ready` pulse with the matching `Nk` code. For a fixed time after the pulse it reports busy, so the expander can finish before a new key arrives.

## Interface
- `EXP_CYCLES`, 16: cycles `busy` stays high after the `k_ready` pulse. Legal range 1..255.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a key load. Sampled only in IDLE.
- `key_len`, input, 2: sampled with `start`. 00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = illegal.
- `abort`, input, 1: cancels a load in progress.
- `wr_valid`, input, 1: host key word valid.
- `wr_data`, input, 32: host key word.
- `wr_ready`, output, 1: loader accepts a word this cycle.
- `CipherKey`, output, 256: assembled key. The first word written lands in bits [31:0].
- `k_ready`, output, 1: one-cycle key-valid pulse to the expander.
- `Nk`, output, 4: key word count minus one (3, 5 or 7). Valid only with `k_ready`.
- `busy`, output, 1: high in every state except IDLE.
- `err`, output, 1: one-cycle pulse on an illegal `key_len`.
- `reload`, input, 1: present only with `AES_KEY_RELOAD_EN`.

## Operation
- The FSM has four states: IDLE, LOAD, ISSUE and WAIT.
- **IDLE**
  - `start` with `key_len` of 11: pulse `err`, stay in IDLE.
  - `start` with a legal `key_len`: latch the target word count N (4, 6 or 8), clear the word counter and the key register, go to LOAD.
- **LOAD**
  - `wr_ready` = 1.
  - Each cycle with `wr_valid && wr_ready` writes `wr_data` into key word [cnt] (bits 32·cnt+31 .. 32·cnt) and increments cnt.
  - The word that makes cnt = N moves the FSM to ISSUE. Words above N stay zero.
  - `abort` returns to IDLE and clears the key register and cnt. A word presented in the same cycle as `abort` is discarded.
- **ISSUE**, exactly one cycle:
  - `k_ready` = 1.
  - `CipherKey` = assembled key.
  - `Nk` = N−1.
  - Next state is WAIT, with the wait counter loaded to `EXP_CYCLES`.
- **WAIT**: the counter decrements each cycle and the FSM returns to IDLE when it reaches 0.
- `start` and `abort` are ignored in ISSUE and WAIT. `abort` has no effect in IDLE.
- Outside the ISSUE cycle, `CipherKey` = 0 and `Nk` = 0. The expander latches on the pulse only.
- Reset, mid-operation or otherwise, forces IDLE immediately. All outputs go to 0 and the counters and key register are cleared. No partial `k_ready` is ever issued.

## Timing
- Reset values:
  - `wr_ready` = 0
  - `k_ready` = 0
  - `CipherKey` = 0
  - `Nk` = 0
  - `busy` = 0
  - `err` = 0
- `start` sampled at edge t0 gives `wr_ready` = 1 and `busy` = 1 from cycle t0+1.
- `err` is high in the cycle after the illegal `start`.
- With the last word accepted at edge t:
  - `wr_ready` = 0 and `k_ready` = 1 during cycle t+1.
  - `busy` stays high through cycle t+1+`EXP_CYCLES`.
  - The FSM is back in IDLE, with `busy` = 0, from cycle t+2+`EXP_CYCLES`.
- With back-to-back `wr_valid`, a 128-bit load takes 4 transfer cycles and there is 1 cycle from the last transfer to `k_ready`.
- A `wr_valid` gap stalls LOAD indefinitely. There is no timeout.
- All outputs are registered.

## Configuration
- Macro: `AES_KEY_RELOAD_EN`.
- **Defined**
  - Adds the `reload` input and a `key_vld` flag, set on every ISSUE and cleared only by reset.
  - In IDLE, `reload` with `key_vld` = 1 goes straight to ISSUE, re-sending the last key and `Nk` with no host writes. Timing and WAIT behaviour are unchanged.
  - `start` has priority over `reload` when both are asserted.
  - `reload` with `key_vld` = 0 is ignored.
  - The key register is not cleared on leaving ISSUE.
- **Undefined**
  - There is no `reload` port.
  - The key register is zeroed on the cycle after ISSUE. No key material is retained.

## Test plan
- **128-bit load**: `start` with `key_len`=00, then words 33221100, 77665544, CCAA9988, FFEEDDBB back-to-back. Required: one `k_ready` pulse with `CipherKey`[127:0] = FFEEDDBBCCAA99887766554433221100, upper bits 0 and `Nk`=3. `busy` drops exactly 16+1 cycles after the pulse.
- **256-bit load with stalls**: `key_len`=10, eight words 0x00000001..0x00000008 with `wr_valid` gaps between them. Required: `CipherKey`[255:224] = 00000008, `Nk`=7, and no `k_ready` before the eighth accept.
- **Illegal length**: `key_len`=11 with `start`. Required: `err` is a single-cycle pulse, `busy` stays 0 and `wr_ready` stays 0.
- **Abort**: `key_len`=01, 3 words written, then `abort` together with a fourth word. Required: IDLE next cycle, no `k_ready`. A following 192-bit load produces a clean key with `Nk`=5.
- **Reset and busy**:
  - Assert `rst_n`=0 during WAIT. All outputs are 0 asynchronously.
  - A `start` issued during WAIT is ignored.
- **`AES_KEY_RELOAD_EN`**: after the 128-bit load, pulse `reload` in IDLE. Required: `k_ready` with the identical key and `Nk`=3 one cycle later. `reload` before any load produces nothing.

Source files
------------

// File: rtl/aes_key_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_key_loader: streams 32-bit key words into a 256-bit CipherKey, then    |
// | pulses k_ready with Nk. Optional feature macro: AES_KEY_RELOAD_EN. Rev 1.0 |
// +----------------------------------------------------------------------------+
module aes_key_loader #(
    parameter int EXP_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic         abort,
    input  logic         wr_valid,
    input  logic [31:0]  wr_data,
`ifdef AES_KEY_RELOAD_EN
    input  logic         reload,
`endif
    output logic         wr_ready,
    output logic [255:0] CipherKey,
    output logic         k_ready,
    output logic [3:0]   Nk,
    output logic         busy,
    output logic         err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]        state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [3:0]        n_words, n_words_nx;
    logic [7:0][31:0]  key_q, key_nx;
    logic [7:0]        wait_cnt, wait_cnt_nx;
    logic              reload_go;

    logic              wr_ready_nx, k_ready_nx, busy_nx, err_nx;
    logic [255:0]      cipher_nx;
    logic [3:0]        nk_nx;

`ifdef AES_KEY_RELOAD_EN
    logic key_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_vld <= 1'b0;
        end else if (state == S_ISSUE) begin
            key_vld <= 1'b1;
        end
    end

    assign reload_go = reload && key_vld;
`else
    assign reload_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            n_words   <= 4'd0;
            key_q     <= '0;
            wait_cnt  <= 8'd0;
            wr_ready  <= 1'b0;
            k_ready   <= 1'b0;
            CipherKey <= '0;
            Nk        <= 4'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            n_words   <= n_words_nx;
            key_q     <= key_nx;
            wait_cnt  <= wait_cnt_nx;
            wr_ready  <= wr_ready_nx;
            k_ready   <= k_ready_nx;
            CipherKey <= cipher_nx;
            Nk        <= nk_nx;
            busy      <= busy_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        n_words_nx  = n_words;
        key_nx      = key_q;
        wait_cnt_nx = wait_cnt;
        case (state)
            S_IDLE: begin
                if (start && key_len != 2'b11) begin
                    state_nx = S_LOAD;
                    cnt_nx   = 4'd0;
                    key_nx   = '0;
                    case (key_len)
                        2'b00:   n_words_nx = 4'd4;
                        2'b01:   n_words_nx = 4'd6;
                        default: n_words_nx = 4'd8;
                    endcase
                end else if (!start && reload_go) begin
                    state_nx = S_ISSUE;
                end
            end
            S_LOAD: begin
                // wr_ready is high throughout LOAD, so wr_valid alone is an accept
                if (abort) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 4'd0;
                    key_nx   = '0;
                end else if (wr_valid) begin
                    key_nx[cnt[2:0]] = wr_data;
                    cnt_nx           = cnt + 4'd1;
                    if (cnt_nx == n_words) begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_nx    = S_WAIT;
                wait_cnt_nx = 8'(EXP_CYCLES);
                cnt_nx      = 4'd0;
`ifndef AES_KEY_RELOAD_EN
                key_nx      = '0;
`endif
            end
            default: begin
                if (wait_cnt <= 8'd1) begin
                    state_nx    = S_IDLE;
                    wait_cnt_nx = 8'd0;
                end else begin
                    wait_cnt_nx = wait_cnt - 8'd1;
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        wr_ready_nx = (state_nx == S_LOAD);
        k_ready_nx  = (state_nx == S_ISSUE);
        cipher_nx   = k_ready_nx ? key_nx : '0;
        nk_nx       = k_ready_nx ? (n_words_nx - 4'd1) : 4'd0;
        busy_nx     = (state_nx != S_IDLE);
        err_nx      = (state == S_IDLE) && start && (key_len == 2'b11);
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_loader.sv
`default_nettype none
// Bench for aes_key_loader: cycle-indexed behavioural model plus directed literal checks.
module tb_aes_key_loader;

    localparam int EXP = 16;
`ifdef AES_KEY_RELOAD_EN
    localparam bit RELOAD_EN = 1'b1;
`else
    localparam bit RELOAD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic         abort = 1'b0;
    logic         wr_valid = 1'b0;
    logic [31:0]  wr_data = 32'd0;
    logic         reload = 1'b0;
    logic         wr_ready;
    logic [255:0] CipherKey;
    logic         k_ready;
    logic [3:0]   Nk;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    aes_key_loader #(.EXP_CYCLES(EXP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_len   (key_len),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
`ifdef AES_KEY_RELOAD_EN
        .reload    (reload),
`endif
        .wr_ready  (wr_ready),
        .CipherKey (CipherKey),
        .k_ready   (k_ready),
        .Nk        (Nk),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: time-stamped events instead of states; idle means no load and past free_at
    int           cyc;
    bit           loading;
    int           target_n;
    int           issue_at, free_at, err_at;
    int           issue_n;
    logic [255:0] issue_key;
    bit           have_key;
    logic [31:0]  words[$];

    function automatic logic [255:0] pack_words();
        logic [255:0] k = '0;
        foreach (words[i]) k[i*32 +: 32] = words[i];
        return k;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; loading = 0; target_n = 0; issue_at = -1; free_at = 0;
            err_at = -1; issue_n = 0; issue_key = '0; have_key = 0;
            words.delete();
        end else begin
            if (!loading && cyc >= free_at) begin
                if (start) begin
                    if (key_len == 2'b11) begin
                        err_at = cyc + 1;
                    end else begin
                        loading  = 1;
                        target_n = 4 + 2 * int'(key_len);
                        words.delete();
                    end
                end else if (RELOAD_EN && reload && have_key) begin
                    issue_at  = cyc + 1;
                    free_at   = cyc + 2 + EXP;
                    issue_key = pack_words();
                    issue_n   = target_n;
                end
            end else if (loading) begin
                if (abort) begin
                    loading = 0;
                    words.delete();
                end else if (wr_valid) begin
                    words.push_back(wr_data);
                    if (words.size() == target_n) begin
                        loading   = 0;
                        issue_at  = cyc + 1;
                        free_at   = cyc + 2 + EXP;
                        issue_key = pack_words();
                        issue_n   = target_n;
                        have_key  = 1;
                    end
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_wr_ready", 256'(wr_ready), 256'(loading));
            chk("m_busy", 256'(busy), 256'(loading || cyc < free_at));
            chk("m_k_ready", 256'(k_ready), 256'(cyc == issue_at));
            chk("m_key", CipherKey, (cyc == issue_at) ? issue_key : 256'd0);
            chk("m_nk", 256'(Nk), (cyc == issue_at) ? 256'(issue_n - 1) : 256'd0);
            chk("m_err", 256'(err), 256'(cyc == err_at));
        end
    end

    // Directed helpers: every task begins and ends just after a falling edge
    task automatic idle_inputs();
        start = 0; abort = 0; wr_valid = 0; reload = 0;
    endtask

    task automatic do_start(input logic [1:0] len);
        start = 1; key_len = len;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        repeat (gap) @(negedge clk);
        wr_valid = 1; wr_data = d;
        @(negedge clk);
        wr_valid = 0;
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 256'(busy), 256'(0));
    endtask

    logic [255:0] key128;
    logic [255:0] exp_key;
    logic [31:0]  w[6];
    int           n;

    initial begin
        key128 = {128'd0, 128'hFFEEDDBBCCAA99887766554433221100};
        #2;
        chk("rst_wr_ready", 256'(wr_ready), 256'(0));
        chk("rst_k_ready", 256'(k_ready), 256'(0));
        chk("rst_key", CipherKey, 256'd0);
        chk("rst_busy", 256'(busy), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

`ifdef AES_KEY_RELOAD_EN
        reload = 1;
        @(negedge clk);
        reload = 0;
        chk("reload_before_load", 256'(k_ready), 256'(0));
        @(negedge clk);
`endif

        // 128-bit load, back-to-back
        do_start(2'b00);
        chk("load_wr_ready", 256'(wr_ready), 256'(1));
        chk("load_busy", 256'(busy), 256'(1));
        send_word(32'h33221100, 0);
        send_word(32'h77665544, 0);
        send_word(32'hCCAA9988, 0);
        send_word(32'hFFEEDDBB, 0);
        chk("k128_pulse", 256'(k_ready), 256'(1));
        chk("k128_wr_ready", 256'(wr_ready), 256'(0));
        chk("k128_key", CipherKey, key128);
        chk("k128_nk", 256'(Nk), 256'(3));
        wait_idle("k128_busy", n);
        chk("k128_busy_len", 256'(n), 256'(EXP + 1));

`ifdef AES_KEY_RELOAD_EN
        reload = 1;
        @(negedge clk);
        reload = 0;
        chk("reload_pulse", 256'(k_ready), 256'(1));
        chk("reload_key", CipherKey, key128);
        chk("reload_nk", 256'(Nk), 256'(3));
        wait_idle("reload_busy", n);
`endif

        // 256-bit load with wr_valid gaps
        do_start(2'b10);
        for (int i = 1; i <= 8; i++) begin
            send_word(32'(i), 1 + int'($urandom_range(0, 2)));
            if (i < 8) chk("k256_early_pulse", 256'(k_ready), 256'(0));
        end
        chk("k256_pulse", 256'(k_ready), 256'(1));
        chk("k256_top_word", 256'(CipherKey[255:224]), 256'(32'h8));
        chk("k256_nk", 256'(Nk), 256'(7));
        wait_idle("k256_busy", n);

        // Illegal length
        do_start(2'b11);
        chk("ill_err", 256'(err), 256'(1));
        chk("ill_busy", 256'(busy), 256'(0));
        chk("ill_wr_ready", 256'(wr_ready), 256'(0));
        @(negedge clk);
        chk("ill_err_single", 256'(err), 256'(0));
        chk("ill_wr_ready2", 256'(wr_ready), 256'(0));

        // Abort with a word in the same cycle, then a clean 192-bit load
        do_start(2'b01);
        for (int i = 0; i < 3; i++) send_word($urandom, 0);
        wr_valid = 1; wr_data = 32'hDEADBEEF; abort = 1;
        @(negedge clk);
        wr_valid = 0; abort = 0;
        chk("abort_wr_ready", 256'(wr_ready), 256'(0));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_k_ready", 256'(k_ready), 256'(0));
        do_start(2'b01);
        exp_key = '0;
        for (int i = 0; i < 6; i++) begin
            w[i] = $urandom;
            exp_key[i*32 +: 32] = w[i];
            send_word(w[i], 0);
        end
        chk("k192_pulse", 256'(k_ready), 256'(1));
        chk("k192_key", CipherKey, exp_key);
        chk("k192_nk", 256'(Nk), 256'(5));

        // start during WAIT is ignored, then reset mid-WAIT
        repeat (3) @(negedge clk);
        start = 1; key_len = 2'b00;
        @(negedge clk);
        start = 0;
        chk("wait_start_ignored", 256'(wr_ready), 256'(0));
        chk("wait_busy", 256'(busy), 256'(1));
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_wr_ready", 256'(wr_ready), 256'(0));
        chk("arst_k_ready", 256'(k_ready), 256'(0));
        chk("arst_key", CipherKey, 256'd0);
        chk("arst_nk", 256'(Nk), 256'(0));
        chk("arst_err", 256'(err), 256'(0));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            start    = ($urandom_range(0, 5) == 0);
            key_len  = 2'($urandom_range(0, 3));
            abort    = ($urandom_range(0, 19) == 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = $urandom;
            reload   = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        idle_inputs();
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
